// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Purpose  : Single-clock parametrised FIFO with occupancy count, watermarks,
//             read-valid strobe and sticky overflow/underflow flags.
//             Define FIFO_FWFT_EN for first-word-fall-through reads.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         wr,
    input  logic                         rd,
    input  logic                         clr_err,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] c_AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Status flags derive only from the registered count.
    assign full         = (r_count == c_DEPTH_CNT);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_AF_CNT);
    assign almost_empty = (r_count <= c_AE_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr && !full;
    assign w_rd_acc = rd && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd && empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; zero while empty so stale memory never leaks.
    assign rdata    = empty ? '0 : r_mem[r_rptr];
    assign rd_valid = !empty;
`else
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata <= r_mem[r_rptr];
            end
        end
    end

    assign rdata    = r_rdata;
    assign rd_valid = r_rd_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Purpose  : Self-checking bench for sync_fifo_param (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wdata = '0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wdata        (wdata),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .rdata        (rdata),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] wdata;
        logic [4:0] cnt;
        logic       rv;
        logic [7:0] rdata;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic w, logic rr, logic c, logic [7:0] d,
                                logic [4:0] n, logic v, logic [7:0] q, logic o, logic u);
        vec_t t;
        t.rst = r; t.wr = w; t.rd = rr; t.clr = c; t.wdata = d;
        t.cnt = n; t.rv = v; t.rdata = q; t.ovf = o; t.udf = u;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; return 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr = w; rd = r; clr_err = c; wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    // Pop one word (optionally writing alongside) and check it arrives per read mode.
    task automatic pop(input string name, input logic [7:0] exp, input logic w, input logic [7:0] d);
`ifdef FIFO_FWFT_EN
        chk({name, ".rv"}, rd_valid, 1'b1);
        chk({name, ".data"}, rdata, exp);
        cyc(w, 1'b1, 1'b0, d);
`else
        cyc(w, 1'b1, 1'b0, d);
        chk({name, ".rv"}, rd_valid, 1'b1);
        chk({name, ".data"}, rdata, exp);
`endif
    endtask

    initial begin
        logic [7:0] mq[$];
        logic [7:0] exp_d;
        int wrote;
        int ncyc;
        logic w, r, wa, ra;
        logic [7:0] d;

        // ---------------- table: reset, fill, overflow, drain, underflow, clear
        tbl.push_back(mk(1, 1, 1, 0, 8'h77, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h77, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 1, 0, 0, 8'(i), 5'(i + 1), 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'hAA, 16, 0, 8'h00, 1, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 0, 1, 0, 8'h00, 5'(15 - i), 1, 8'(i), 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 8'h0F, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 8'h0F, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            rst = tbl[i].rst;
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].wdata);
            rst = 1'b0;
            chk({nm, ".count"}, count, tbl[i].cnt);
            chk({nm, ".full"}, full, tbl[i].cnt == 16);
            chk({nm, ".empty"}, empty, tbl[i].cnt == 0);
            chk({nm, ".afull"}, almost_full, tbl[i].cnt >= 14);
            chk({nm, ".aempty"}, almost_empty, tbl[i].cnt <= 2);
            chk({nm, ".ovf"}, overflow, tbl[i].ovf);
            chk({nm, ".udf"}, underflow, tbl[i].udf);
`ifndef FIFO_FWFT_EN
            chk({nm, ".rv"}, rd_valid, tbl[i].rv);
            chk({nm, ".rdata"}, rdata, tbl[i].rdata);
`endif
        end

        // ---------------- simultaneous wr+rd at count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        chk("mid.count_before", count, 5);
        pop("mid.pop0", 8'h10, 1'b1, 8'h15);
        chk("mid.count_after", count, 5);
        for (int i = 1; i < 6; i++) pop($sformatf("mid.pop%0d", i), 8'(8'h10 + i), 1'b0, 8'h00);
        chk("mid.empty", empty, 1'b1);

        // ---------------- simultaneous wr+rd at empty
        cyc(1'b1, 1'b1, 1'b0, 8'h30);
        chk("emp.count", count, 1);
        chk("emp.udf", underflow, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("emp.rv", rd_valid, 1'b0);
`endif
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("emp.clr", underflow, 1'b0);
        pop("emp.pop", 8'h30, 1'b0, 8'h00);

        // ---------------- simultaneous wr+rd at full
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        chk("ful.full", full, 1'b1);
        pop("ful.pop0", 8'h40, 1'b1, 8'hEE);
        chk("ful.count", count, 15);
        chk("ful.ovf", overflow, 1'b1);
        for (int i = 1; i < 16; i++) pop($sformatf("ful.pop%0d", i), 8'(8'h40 + i), 1'b0, 8'h00);
        chk("ful.empty", empty, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("ful.clr", overflow, 1'b0);

        // ---------------- random stream with gaps, queue reference
        wrote = 0;
        ncyc = 0;
        while ((wrote < 40 || mq.size() > 0) && ncyc < 2000) begin
            w = (wrote < 40) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            d = 8'($urandom);
            wa = w && (mq.size() < 16);
            ra = r && (mq.size() > 0);
`ifdef FIFO_FWFT_EN
            if (mq.size() > 0) chk("rnd.head", rdata, mq[0]);
`endif
            exp_d = 8'h00;
            if (ra) exp_d = mq.pop_front();
            if (wa) begin
                mq.push_back(d);
                wrote++;
            end
            cyc(w, r, 1'b0, d);
`ifndef FIFO_FWFT_EN
            chk("rnd.rv", rd_valid, ra);
            if (ra) chk("rnd.data", rdata, exp_d);
`endif
            chk("rnd.count", count, 5'(mq.size()));
            ncyc++;
        end
        chk("rnd.timeout", ncyc < 2000, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // ---------------- reset mid-operation at count 9
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        chk("rst.count9", count, 9);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("rst.count", count, 0);
        chk("rst.empty", empty, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("rst.udf", underflow, 1'b1);
        chk("rst.rv", rd_valid, 1'b0);
        chk("rst.count_after", count, 0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

`ifdef FIFO_FWFT_EN
        // ---------------- fall-through: head visible without a request
        cyc(1'b1, 1'b0, 1'b0, 8'h5A);
        chk("fwft.rv", rd_valid, 1'b1);
        chk("fwft.data", rdata, 8'h5A);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft.empty", empty, 1'b1);
        chk("fwft.rv_after", rd_valid, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
